// File: rtl/axi_stream_wb_mailbox_master.sv
// axi_stream_wb_mailbox_master: Wishbone master that polls a 64-bit packet mailbox, drains RX lines to tx_* and fills TX lines from rx_*.
// Optional AXI_STREAM_WB_MASTER_POLL_BACKOFF_EN: idle POLL_GAP cycles after a status poll that found nothing to do.
module axi_stream_wb_mailbox_master #(
   parameter int AWIDTH    = 13,
   parameter int CTRL_ADDR = 0,
   parameter int BUF_BASE  = 8,
   parameter int POLL_GAP  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              cyc_o,
   output logic              stb_o,
   output logic              we_o,
   output logic [AWIDTH-1:0] adr_o,
   output logic [31:0]       dat_o,
   input  logic [31:0]       dat_i,
   input  logic              ack_i,
   input  logic [63:0]       rx_tdata,
   input  logic [3:0]        rx_tuser,
   input  logic              rx_tlast,
   input  logic              rx_tvalid,
   output logic              rx_tready,
   output logic [63:0]       tx_tdata,
   output logic [3:0]        tx_tuser,
   output logic              tx_tlast,
   output logic              tx_tvalid,
   input  logic              tx_tready
);
   localparam int LW = AWIDTH - 3;
   localparam int PW = 29 - AWIDTH;
   typedef enum logic [3:0] {
      POLL, DECIDE, GAP, RD_HI, RD_LO, PRESENT, REL_SET, REL_CLR,
      FILL_BEAT, WR_HI, WR_LO, COMMIT, UNCOMMIT
   } state_t;
`ifdef AXI_STREAM_WB_MASTER_POLL_BACKOFF_EN
   localparam state_t REPOLL = GAP;
`else
   localparam state_t REPOLL = POLL;
`endif
   state_t state, state_n;
   logic [31:0] status;
   logic [LW-1:0] n, n_inc, lines;
   logic [63:0] bdata;
   logic [3:0] buser;
   logic blast, ovf;
   logic rx_flag, tx_flag, tx_err;
   logic [AWIDTH-1:0] tx_bytes, line_adr;
   logic ack, req, req_we;
   logic [AWIDTH-1:0] req_adr;
   logic [31:0] req_dat;
   logic unused_status;
   assign unused_status = ^status[28:AWIDTH];
   assign lines = status[AWIDTH-1:3];
   assign n_inc = n + 1'b1;
   assign line_adr = AWIDTH'(BUF_BASE) + {n, 3'b000};
   assign ack = cyc_o & stb_o & ack_i;
   assign tx_tvalid = (state == PRESENT);
   assign rx_tready = (state == FILL_BEAT);
`ifdef AXI_STREAM_WB_MASTER_POLL_BACKOFF_EN
   localparam int GW = $clog2(POLL_GAP + 1);
   logic [GW-1:0] gap_cnt;
   // backoff counter loaded on every decision, counts down while idling
   always_ff @(posedge clk_i) begin
      if (rst_i) gap_cnt <= '0;
      else if (state == DECIDE) gap_cnt <= GW'(POLL_GAP - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
   end
`endif
   // state register
   always_ff @(posedge clk_i) state <= rst_i ? POLL : state_n;
   // next state and the single Wishbone request each bus state wants to issue
   always_comb begin
      state_n = state;
      req = 1'b0;
      req_we = 1'b0;
      req_adr = '0;
      req_dat = '0;
      case (state)
         POLL: begin
            req = ~cyc_o;
            req_adr = AWIDTH'(CTRL_ADDR);
            if (ack) state_n = DECIDE;
         end
         DECIDE: state_n = status[31] ? (lines == '0 ? REL_SET : RD_HI) : (status[30] && rx_tvalid) ? FILL_BEAT : REPOLL;
`ifdef AXI_STREAM_WB_MASTER_POLL_BACKOFF_EN
         GAP: if (gap_cnt == '0) state_n = POLL;
`endif
         RD_HI: begin
            req = ~cyc_o;
            req_adr = line_adr;
            if (ack) state_n = RD_LO;
         end
         RD_LO: begin
            req = ~cyc_o;
            req_adr = line_adr + AWIDTH'(4);
            if (ack) state_n = PRESENT;
         end
         PRESENT: if (tx_tready) state_n = tx_tlast ? REL_SET : RD_HI;
         REL_SET, REL_CLR: begin
            req = ~cyc_o;
            req_we = 1'b1;
            req_adr = AWIDTH'(CTRL_ADDR);
            req_dat = {state == REL_SET, tx_flag, tx_err, {PW{1'b0}}, tx_bytes};
            if (ack) state_n = (state == REL_SET) ? REL_CLR : POLL;
         end
         FILL_BEAT: if (rx_tvalid) state_n = (n == '1) ? (rx_tlast ? COMMIT : FILL_BEAT) : WR_HI;
         WR_HI: begin
            req = ~cyc_o;
            req_we = 1'b1;
            req_adr = line_adr;
            req_dat = bdata[63:32];
            if (ack) state_n = WR_LO;
         end
         WR_LO: begin
            req = ~cyc_o;
            req_we = 1'b1;
            req_adr = line_adr + AWIDTH'(4);
            req_dat = bdata[31:0];
            if (ack) state_n = blast ? COMMIT : FILL_BEAT;
         end
         COMMIT: begin
            req = ~cyc_o;
            req_we = 1'b1;
            req_adr = AWIDTH'(CTRL_ADDR);
            req_dat = {rx_flag, 1'b1, buser[3] | ovf, {PW{1'b0}}, n, buser[2:0]};
            if (ack) state_n = UNCOMMIT;
         end
         UNCOMMIT: begin
            req = ~cyc_o;
            req_we = 1'b1;
            req_adr = AWIDTH'(CTRL_ADDR);
            req_dat = {rx_flag, 1'b0, tx_err, {PW{1'b0}}, tx_bytes};
            if (ack) state_n = POLL;
         end
         default: state_n = POLL;
      endcase
   end
   // Wishbone strobes: launched from idle, held until ack, then fully cleared for a cycle
   always_ff @(posedge clk_i) begin
      if (rst_i || ack) begin
         cyc_o <= 1'b0;
         stb_o <= 1'b0;
         we_o <= 1'b0;
         adr_o <= '0;
         dat_o <= '0;
      end else if (req) begin
         cyc_o <= 1'b1;
         stb_o <= 1'b1;
         we_o <= req_we;
         adr_o <= req_adr;
         dat_o <= req_dat;
      end
   end
   // status capture, line counting, beat buffering and ctrl shadows
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         status <= '0;
         n <= '0;
         bdata <= '0;
         buser <= '0;
         blast <= 1'b0;
         ovf <= 1'b0;
         rx_flag <= 1'b0;
         tx_flag <= 1'b0;
         tx_err <= 1'b0;
         tx_bytes <= '0;
         tx_tdata <= '0;
         tx_tlast <= 1'b0;
         tx_tuser <= '0;
      end else begin
         if (state == POLL && ack) status <= dat_i;
         if (state == DECIDE) begin
            n <= '0;
            ovf <= 1'b0;
         end
         if (state == RD_HI && ack) tx_tdata[63:32] <= dat_i;
         if (state == RD_LO && ack) begin
            tx_tdata[31:0] <= dat_i;
            tx_tlast <= (n_inc == lines);
            tx_tuser <= (n_inc == lines) ? {status[29], status[2:0]} : 4'h0;
         end
         if (state == PRESENT && tx_tready && !tx_tlast) n <= n_inc;
         if (state == FILL_BEAT && rx_tvalid) begin
            bdata <= rx_tdata;
            buser <= rx_tuser;
            blast <= rx_tlast;
            if (n == '1) ovf <= 1'b1;
         end
         if (state == WR_LO && ack) n <= n_inc;
         if (state == REL_SET && req) rx_flag <= 1'b1;
         if (state == REL_CLR && req) rx_flag <= 1'b0;
         if (state == COMMIT && req) begin
            tx_flag <= 1'b1;
            tx_err <= buser[3] | ovf;
            tx_bytes <= {n, buser[2:0]};
         end
         if (state == UNCOMMIT && req) tx_flag <= 1'b0;
      end
   end
endmodule

// File: doc/axi_stream_wb_mailbox_master.md
# axi_stream_wb_mailbox_master

Wishbone-master engine that services a 64-bit packet mailbox slave (status/ctrl register plus RX and TX line buffers) without a processor. It polls the status word, drains each completed inbound packet from the slave's RX buffer onto an AXI stream, and fills the slave's TX buffer from an AXI stream, then commits it. It sits on the Wishbone side of the mailbox, where firmware would otherwise run the handshake.

## Interface
Parameters:
- AWIDTH, 13: Wishbone byte-address width; buffer holds 2^(AWIDTH-3) 64-bit lines.
- CTRL_ADDR, 0: byte address of the slave's ctrl/status register.
- BUF_BASE, 8: byte address of buffer line 0. Line n upper word is at BUF_BASE+8n; the lower word is at +4.
- POLL_GAP, 16: idle cycles between status polls (used only with the macro).

Ports:
- clk_i  in  1  clock; single clock domain. Reset is synchronous and active-high.
- rst_i  in  1  synchronous reset, active-high.
- cyc_o, stb_o, we_o  out  1 each  Wishbone master strobes.
- adr_o  out  AWIDTH  byte address.
- dat_o  out  32  write data.
- dat_i  in  32  read data.
- ack_i  in  1  transfer acknowledge.
- rx_tdata/rx_tuser/rx_tlast/rx_tvalid  in  64/4/1/1  stream to load into the slave TX buffer.
- rx_tready  out  1  input-stream ready.
- tx_tdata/tx_tuser/tx_tlast/tx_tvalid  out  64/4/1/1  stream drained from the slave RX buffer.
- tx_tready  in  1  output-stream ready.

## Operation
Status word fields:
- [31] RX packet ready.
- [30] TX slot free.
- [29] RX error.
- [AWIDTH-1:0] RX byte count, encoded as {lines, residual[2:0]}.

Ctrl writes always carry the shadow registers rx_flag, tx_flag, tx_err and tx_bytes in the layout {rx_flag, tx_flag, tx_err, 0…, tx_bytes}. All shadows reset to 0.

Wishbone cycle rules:
- Single transfer only.
- cyc_o, stb_o, we_o, adr_o and dat_o are held stable until ack_i.
- All are deasserted for at least one cycle after ack.

FSM states:
- POLL: read CTRL_ADDR, capture status, then go to DECIDE.
- DECIDE:
  - If status[31] is set, go to DRAIN. RX drain has priority.
  - Else if status[30] is set and rx_tvalid is high, go to FILL.
  - Else return to POLL.
- DRAIN (reader):
  - lines = status[AWIDTH-1:3].
  - If lines == 0, go straight to REL_SET with no output.
  - Per line: RD_HI reads BUF_BASE+8n into tdata[63:32]; RD_LO reads +4 into tdata[31:0]; PRESENT holds tx_tvalid until tx_tready.
  - On the last line, tx_tlast=1 and tx_tuser={status[29], status[2:0]}. On other lines, tx_tuser=0.
  - REL_SET writes ctrl with rx_flag=1. REL_CLR then writes ctrl with rx_flag=0. Both go back to POLL.
- FILL (writer):
  - FILL_BEAT asserts rx_tready for exactly one accepted beat and registers it.
  - WR_HI writes tdata[63:32] to line n upper, then WR_LO writes tdata[31:0] to lower. The upper word is always written before the lower, because the slave commits the line on the lower write.
  - Repeat until a beat with tlast.
  - COMMIT writes ctrl with tx_flag=1, tx_bytes={lines, tuser[2:0]}, tx_err=tuser[3]|ovf.
  - UNCOMMIT writes ctrl with tx_flag=0. The slave finishes streaming, then frees the slot. Go to POLL.
- Overflow:
  - Capacity is 2^(AWIDTH-3)-1 lines, so the line count never wraps to 0.
  - Beats beyond capacity are accepted and discarded until tlast, and ovf is set.
- Reset mid-operation:
  - All strobes drop on the next edge.
  - FSM returns to POLL; shadows and line counters clear.
  - Any partial packet is abandoned. The slave must share the reset.

## Timing
Reset values of all outputs: cyc_o, stb_o, we_o, adr_o, dat_o, rx_tready, tx_tvalid, tx_tlast, tx_tuser and tx_tdata are all 0.

Latencies and handshake rules:
- DRAIN line: tx_tvalid rises the cycle after the RD_LO ack. It stays high with stable tdata, tlast and tuser until tx_tready. The next RD_HI is issued the cycle after the handshake.
- FILL: rx_tready is high only in FILL_BEAT and drops the cycle after rx_tvalid&rx_tready. WR_HI is issued the following cycle.
- A ctrl write with tx_flag=1 is followed by the tx_flag=0 write no sooner than 2 cycles later. The slave therefore sees tx_flag=1 for at least one cycle.
- An ack_i that arrives while no strobe is asserted is ignored.

## Configuration
- AXI_STREAM_WB_MASTER_POLL_BACKOFF_EN:
  - Defined: after DECIDE returns to POLL with nothing to do, the FSM idles POLL_GAP cycles before the next status read.
  - Undefined: the next status read issues after the mandatory single idle cycle.
  - Drain/fill paths are identical either way.

## Test plan
- Status=0x8000_0013 (2 lines, residual 3), buffer upper/lower words A,B,C,D -> two tx beats: {A,B} (tlast=0, tuser=0), then {C,D} (tlast=1, tuser=4'h3). Then ctrl writes 0x8000_0000 followed by 0x0000_0000.
- Status=0xA000_0008 -> one beat with tuser=4'b1000 and tlast=1.
- Input packet of 3 beats with last tuser=4'h5, status[30]=1 -> 6 writes in hi/lo order to BUF_BASE..BUF_BASE+20. Then ctrl writes 0x4000_001D followed by 0x0000_001D.
- AWIDTH=6 (7-line capacity), 9-beat input packet -> 14 buffer writes, ctrl tx_bytes={7,res}, tx_err=1, all 9 beats accepted.
- status[31] and status[30] both set with rx_tvalid=1 -> drain completes before any fill write.
- rst_i asserted during WR_LO (stb_o high) -> next cycle all outputs 0, and the first transfer afterwards is a status read at CTRL_ADDR.
